// File: rtl/hazard_controller.sv
// Hazard controller for a 5-stage RV32I pipeline: shadow EX/MEM/WB records, stall/flush/bubble
// generation and EX operand forwarding selects. Optional perf counters under HAZARD_PERF_CNT_EN.
module hazard_controller #(
    parameter int  XLEN     = 32,
    parameter int  NUM_REGS = 32,
    localparam int RW       = $clog2(NUM_REGS)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            id_valid_i,
    input  logic [6:0]      id_opcode_i,
    input  logic [RW-1:0]   id_rd_i,
    input  logic [RW-1:0]   id_rs1_i,
    input  logic [RW-1:0]   id_rs2_i,
    input  logic            ex_branch_taken_i,
    input  logic            mem_busy_i,
    output logic            stall_if_o,
    output logic            stall_id_o,
    output logic            flush_if_o,
    output logic            bubble_ex_o,
    output logic [1:0]      fwd_a_sel_o,
    output logic [1:0]      fwd_b_sel_o,
    output logic            ex_valid_o,
    output logic            mem_valid_o,
    output logic            wb_valid_o,
    output logic [XLEN-1:0] perf_stall_cnt_o,
    output logic [XLEN-1:0] perf_flush_cnt_o
);

    typedef enum logic [6:0] {
        OP_LUI     = 7'b0110111,
        OP_AUIPC   = 7'b0010111,
        OP_JAL     = 7'b1101111,
        OP_JALR    = 7'b1100111,
        OP_BRANCH  = 7'b1100011,
        OP_LOAD    = 7'b0000011,
        OP_STORE   = 7'b0100011,
        OP_REG_IMM = 7'b0010011,
        OP_REG_REG = 7'b0110011
    } opcode_t;

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rd;
        logic [RW-1:0] rs1;
        logic [RW-1:0] rs2;
        logic          wr;
        logic          ld;
    } stage_rec_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    stage_rec_t ex_q, mem_q, wb_q;
    stage_rec_t ex_d, mem_d, wb_d;
    stage_rec_t id_rec;
    logic       use_rs1, use_rs2, dec_wr, dec_ld;
    logic       load_use, branch_flush;
    logic       stall_evt, flush_evt;

    // Unused sources are stored as x0 so they can never match a destination.
    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        dec_wr  = 1'b0;
        dec_ld  = 1'b0;
        case (id_opcode_i)
            OP_LUI, OP_AUIPC, OP_JAL: dec_wr = 1'b1;
            OP_JALR, OP_REG_IMM: begin
                dec_wr  = 1'b1;
                use_rs1 = 1'b1;
            end
            OP_LOAD: begin
                dec_wr  = 1'b1;
                dec_ld  = 1'b1;
                use_rs1 = 1'b1;
            end
            OP_REG_REG: begin
                dec_wr  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_STORE, OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            default: ;
        endcase
        id_rec.valid = id_valid_i;
        id_rec.rd    = id_rd_i;
        id_rec.rs1   = use_rs1 ? id_rs1_i : '0;
        id_rec.rs2   = use_rs2 ? id_rs2_i : '0;
        id_rec.wr    = dec_wr & (id_rd_i != '0);
        id_rec.ld    = dec_ld;
    end

    assign load_use = id_valid_i & ex_q.valid & ex_q.ld & ex_q.wr &
                      (((id_rec.rs1 != '0) & (id_rec.rs1 == ex_q.rd)) |
                       ((id_rec.rs2 != '0) & (id_rec.rs2 == ex_q.rd)));
    assign branch_flush = ex_q.valid & ex_branch_taken_i;

    always_comb begin
        stall_if_o  = 1'b0;
        stall_id_o  = 1'b0;
        flush_if_o  = 1'b0;
        bubble_ex_o = 1'b0;
        stall_evt   = 1'b0;
        flush_evt   = 1'b0;
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        if (rst_i) begin
            ex_d  = '0;
            mem_d = '0;
            wb_d  = '0;
        end else if (mem_busy_i) begin
            stall_if_o = 1'b1;
            stall_id_o = 1'b1;
        end else if (branch_flush) begin
            flush_if_o  = 1'b1;
            bubble_ex_o = 1'b1;
            flush_evt   = 1'b1;
            ex_d        = '0;
            mem_d       = ex_q;
            wb_d        = mem_q;
        end else if (load_use) begin
            stall_if_o  = 1'b1;
            stall_id_o  = 1'b1;
            bubble_ex_o = 1'b1;
            stall_evt   = 1'b1;
            ex_d        = '0;
            mem_d       = ex_q;
            wb_d        = mem_q;
        end else begin
            ex_d  = id_rec;
            mem_d = ex_q;
            wb_d  = mem_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    // MEM holds the youngest value; a load in MEM has no data yet, so it never forwards.
    function automatic logic [1:0] fwd_sel(input logic [RW-1:0] src,
                                           input stage_rec_t mem_r,
                                           input stage_rec_t wb_r);
        if (src == '0)
            return FWD_RF;
        if (mem_r.valid & mem_r.wr & ~mem_r.ld & (mem_r.rd == src))
            return FWD_MEM;
        if (wb_r.valid & wb_r.wr & (wb_r.rd == src))
            return FWD_WB;
        return FWD_RF;
    endfunction

    always_comb begin
        fwd_a_sel_o = FWD_RF;
        fwd_b_sel_o = FWD_RF;
        if (!rst_i && ex_q.valid) begin
            fwd_a_sel_o = fwd_sel(ex_q.rs1, mem_q, wb_q);
            fwd_b_sel_o = fwd_sel(ex_q.rs2, mem_q, wb_q);
        end
    end

    assign ex_valid_o  = ex_q.valid;
    assign mem_valid_o = mem_q.valid;
    assign wb_valid_o  = wb_q.valid;

    logic unused_rec_bits;
    assign unused_rec_bits = ^{mem_q.rs1, mem_q.rs2, wb_q.rs1, wb_q.rs2, wb_q.ld};

`ifdef HAZARD_PERF_CNT_EN
    logic [XLEN-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_evt)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_evt)
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign perf_stall_cnt_o = stall_cnt_q;
    assign perf_flush_cnt_o = flush_cnt_q;
`else
    logic unused_evts;
    assign unused_evts      = stall_evt ^ flush_evt;
    assign perf_stall_cnt_o = '0;
    assign perf_flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed pipeline scenarios followed by random instruction
// streams, checked against an in-bench model of the stage records.
module tb_hazard_controller;
    localparam int XLEN = 32;

    localparam logic [6:0] LUI     = 7'b0110111;
    localparam logic [6:0] AUIPC   = 7'b0010111;
    localparam logic [6:0] JAL     = 7'b1101111;
    localparam logic [6:0] JALR    = 7'b1100111;
    localparam logic [6:0] BRANCH  = 7'b1100011;
    localparam logic [6:0] LOAD    = 7'b0000011;
    localparam logic [6:0] STORE   = 7'b0100011;
    localparam logic [6:0] REG_IMM = 7'b0010011;
    localparam logic [6:0] REG_REG = 7'b0110011;
    localparam logic [6:0] BADOP   = 7'b1111111;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            id_valid = 1'b0;
    logic [6:0]      id_opcode = 7'd0;
    logic [4:0]      id_rd = 5'd0, id_rs1 = 5'd0, id_rs2 = 5'd0;
    logic            ex_branch_taken = 1'b0;
    logic            mem_busy = 1'b0;
    logic            stall_if, stall_id, flush_if, bubble_ex;
    logic [1:0]      fwd_a_sel, fwd_b_sel;
    logic            ex_valid, mem_valid, wb_valid;
    logic [XLEN-1:0] perf_stall_cnt, perf_flush_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hazard_controller #(.XLEN(XLEN), .NUM_REGS(32)) dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_opcode_i(id_opcode),
        .id_rd_i(id_rd), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .ex_branch_taken_i(ex_branch_taken), .mem_busy_i(mem_busy),
        .stall_if_o(stall_if), .stall_id_o(stall_id), .flush_if_o(flush_if),
        .bubble_ex_o(bubble_ex), .fwd_a_sel_o(fwd_a_sel), .fwd_b_sel_o(fwd_b_sel),
        .ex_valid_o(ex_valid), .mem_valid_o(mem_valid), .wb_valid_o(wb_valid),
        .perf_stall_cnt_o(perf_stall_cnt), .perf_flush_cnt_o(perf_flush_cnt)
    );

    // Model: an instruction is described by what it writes and which registers it reads.
    typedef struct {
        bit v;
        int rd;
        int s1;
        int s2;
        bit wr;
        bit ld;
    } rec_t;

    rec_t        m_ex, m_mem, m_wb;
    logic [31:0] m_scnt = 0, m_fcnt = 0;

    function automatic rec_t decode(bit v, logic [6:0] op, int rd, int rs1, int rs2);
        rec_t r;
        r.v  = v;
        r.rd = rd;
        r.wr = (op inside {REG_IMM, LOAD, JALR, REG_REG, LUI, AUIPC, JAL}) && rd != 0;
        r.ld = (op == LOAD);
        r.s1 = (op inside {REG_IMM, LOAD, JALR, REG_REG, STORE, BRANCH}) ? rs1 : 0;
        r.s2 = (op inside {REG_REG, STORE, BRANCH}) ? rs2 : 0;
        return r;
    endfunction

    function automatic logic [1:0] model_fwd(int src);
        if (!m_ex.v || src == 0) return 2'b00;
        if (m_mem.v && m_mem.wr && !m_mem.ld && m_mem.rd == src) return 2'b01;
        if (m_wb.v && m_wb.wr && m_wb.rd == src) return 2'b10;
        return 2'b00;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(bit r, bit v, logic [6:0] op, int rd, int rs1, int rs2, bit tk, bit busy);
        rec_t idr;
        bit   e_flush, e_lu, e_stall;
        logic [1:0] e_fa, e_fb;
        @(negedge clk);
        rst = r; id_valid = v; id_opcode = op;
        id_rd = rd[4:0]; id_rs1 = rs1[4:0]; id_rs2 = rs2[4:0];
        ex_branch_taken = tk; mem_busy = busy;
        #1;
        idr     = decode(v, op, rd, rs1, rs2);
        e_flush = !r && !busy && m_ex.v && tk;
        e_lu    = !r && !busy && !e_flush && v && m_ex.v && m_ex.ld && m_ex.wr &&
                  ((idr.s1 != 0 && idr.s1 == m_ex.rd) || (idr.s2 != 0 && idr.s2 == m_ex.rd));
        e_stall = !r && (busy || e_lu);
        e_fa    = r ? 2'b00 : model_fwd(m_ex.s1);
        e_fb    = r ? 2'b00 : model_fwd(m_ex.s2);
        check("stall_if", 32'(stall_if), 32'(e_stall));
        check("stall_id", 32'(stall_id), 32'(e_stall));
        check("flush_if", 32'(flush_if), 32'(e_flush));
        check("bubble_ex", 32'(bubble_ex), 32'(e_flush || e_lu));
        check("fwd_a_sel", 32'(fwd_a_sel), 32'(e_fa));
        check("fwd_b_sel", 32'(fwd_b_sel), 32'(e_fb));
        check("ex_valid", 32'(ex_valid), 32'(m_ex.v));
        check("mem_valid", 32'(mem_valid), 32'(m_mem.v));
        check("wb_valid", 32'(wb_valid), 32'(m_wb.v));
`ifdef HAZARD_PERF_CNT_EN
        check("perf_stall_cnt", perf_stall_cnt, m_scnt);
        check("perf_flush_cnt", perf_flush_cnt, m_fcnt);
`else
        check("perf_stall_cnt", perf_stall_cnt, 32'd0);
        check("perf_flush_cnt", perf_flush_cnt, 32'd0);
`endif
        if (r) begin
            m_ex = '{default: 0}; m_mem = '{default: 0}; m_wb = '{default: 0};
            m_scnt = 0; m_fcnt = 0;
        end else if (!busy) begin
            m_wb  = m_mem;
            m_mem = m_ex;
            if (e_flush || e_lu) m_ex = '{default: 0};
            else                 m_ex = idr;
            if (e_flush) m_fcnt = m_fcnt + 1;
            if (e_lu)    m_scnt = m_scnt + 1;
        end
    endtask

    task automatic nop(bit busy);
        step(0, 0, REG_IMM, 0, 0, 0, 0, busy);
    endtask

    task automatic do_reset();
        step(1, 0, REG_IMM, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [6:0] ops [10];
        ops = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, REG_IMM, REG_REG, BADOP};
        m_ex = '{default: 0}; m_mem = '{default: 0}; m_wb = '{default: 0};

        do_reset();
        do_reset();
        check("reset_ex_valid", 32'(ex_valid), 32'd0);

        // add x5,x1,x2 ; sub x6,x5,x3
        step(0, 1, REG_REG, 5, 1, 2, 0, 0);
        step(0, 1, REG_REG, 6, 5, 3, 0, 0);
        nop(0);
        check("alu_fwd_a", 32'(fwd_a_sel), 32'd1);
        check("alu_no_stall", 32'(stall_if), 32'd0);

        // lw x7,0(x1) ; add x8,x7,x2
        do_reset();
        step(0, 1, LOAD, 7, 1, 0, 0, 0);
        step(0, 1, REG_REG, 8, 7, 2, 0, 0);
        check("lu_stall", 32'(stall_if), 32'd1);
        check("lu_bubble", 32'(bubble_ex), 32'd1);
        step(0, 1, REG_REG, 8, 7, 2, 0, 0);
        check("lu_one_cycle", 32'(stall_if), 32'd0);
        nop(0);
        check("lu_fwd_a_wb", 32'(fwd_a_sel), 32'd2);
`ifdef HAZARD_PERF_CNT_EN
        check("lu_perf_stall", perf_stall_cnt, 32'd1);
`endif

        // addi x0,x1,5 ; add x9,x0,x0
        step(0, 1, REG_IMM, 0, 1, 0, 0, 0);
        step(0, 1, REG_REG, 9, 0, 0, 0, 0);
        check("x0_no_stall", 32'(stall_if), 32'd0);
        nop(0);
        check("x0_fwd_a", 32'(fwd_a_sel), 32'd0);
        check("x0_fwd_b", 32'(fwd_b_sel), 32'd0);

        // taken branch overrides a pending load-use
        do_reset();
        step(0, 1, LOAD, 7, 1, 0, 0, 0);
        step(0, 1, REG_REG, 8, 7, 2, 1, 0);
        check("br_flush", 32'(flush_if), 32'd1);
        check("br_bubble", 32'(bubble_ex), 32'd1);
        check("br_no_stall", 32'(stall_if), 32'd0);
        nop(0);
`ifdef HAZARD_PERF_CNT_EN
        check("br_perf_flush", perf_flush_cnt, 32'd1);
        check("br_perf_stall", perf_stall_cnt, 32'd0);
`endif

        // mem_busy freeze for 3 cycles
        step(0, 1, REG_REG, 5, 1, 2, 0, 0);
        step(0, 1, REG_REG, 6, 5, 3, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, LOAD, 4, 6, 0, 1, 1);
            check("busy_stall", 32'(stall_if), 32'd1);
            check("busy_fwd_a", 32'(fwd_a_sel), 32'd1);
        end
        nop(0);
        check("busy_resume_fwd_a", 32'(fwd_a_sel), 32'd1);

        // reset in the middle of a load-use stall
        step(0, 1, LOAD, 7, 1, 0, 0, 0);
        step(1, 1, REG_REG, 8, 7, 2, 0, 0);
        step(0, 1, REG_REG, 8, 7, 2, 0, 0);
        check("rst_lu_stall", 32'(stall_if), 32'd0);
        check("rst_lu_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_lu_wb_valid", 32'(wb_valid), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 85,
                 ops[$urandom_range(0, 9)],
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)),
                 $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 15);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Hazard controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Tracks in-flight destination registers for the EX, MEM and WB stages in its own shadow records, so the datapath only supplies ID-stage fields and the branch outcome.
- Generates stall, flush and bubble controls, plus forwarding selects for the instruction in EX.
- Decodes register-write/read usage directly from the opcode_t encodings.

Parameters:
- XLEN, 32, datapath width; only used for performance counter width.
- NUM_REGS, 32, architectural register count; register index width is $clog2(NUM_REGS)=5.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_opcode  in  7  opcode of ID instruction (opcode_t)
- id_rd  in  5  destination of ID instruction
- id_rs1  in  5  source 1 of ID instruction
- id_rs2  in  5  source 2 of ID instruction
- ex_branch_taken  in  1  EX resolved a taken branch/JAL/JALR this cycle; ignored unless ex_valid=1
- mem_busy  in  1  data memory not ready; freeze whole pipeline
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID register
- flush_if  out  1  squash IF/ID register contents
- bubble_ex  out  1  load NOP into ID/EX register
- fwd_a_sel  out  2  EX operand A source: 00 regfile, 01 MEM ALU result, 10 WB result
- fwd_b_sel  out  2  EX operand B source, same encoding
- ex_valid, mem_valid, wb_valid  out  1 each  shadow stage valid bits
- perf_stall_cnt  out  XLEN  load-use stall cycles (optional feature)
- perf_flush_cnt  out  XLEN  taken-branch flushes (optional feature)

Behaviour:
- Stage record fields: valid, rd, rs1, rs2, wr (writes rd), ld (is load).
- Opcode decode:
  - wr=1 for REG_IMM, LOAD, JALR, REG_REG, LUI, AUIPC, JAL.
  - Uses rs1 for all opcodes except LUI, AUIPC, JAL.
  - Uses rs2 for REG_REG, STORE, BRANCH.
  - ld=1 only for LOAD.
  - Unknown opcode: wr=0, no source use, valid still propagates.
  - rd==0 forces wr=0. A source index of 0 never matches.
- Load-use hazard (lu): id_valid & ex.valid & ex.ld & ex.wr & (ex.rd matches a used ID source).
- Priority each cycle: rst > mem_busy > branch flush > lu > normal.
- mem_busy=1:
  - stall_if=stall_id=1; flush_if=bubble_ex=0.
  - All records hold.
  - Counters do not increment.
- Flush (ex_valid & ex_branch_taken, mem_busy=0):
  - flush_if=1, bubble_ex=1, stall_if=stall_id=0.
  - EX gets invalid record; MEM<=EX, WB<=MEM.
  - lu is ignored that cycle.
- lu (no flush, mem_busy=0):
  - stall_if=stall_id=1, bubble_ex=1 for exactly one cycle.
  - EX<=invalid; MEM<=EX, WB<=MEM.
  - Next cycle ex.ld is no longer valid, so lu self-clears.
- Normal: EX<=ID fields (valid=id_valid); MEM<=EX; WB<=MEM.
- Forwarding (combinational from registered records), for operand A using ex.rs1 (B analogous with ex.rs2):
  - 01 if mem.valid & mem.wr & ~mem.ld & mem.rd==ex.rs1.
  - else 10 if wb.valid & wb.wr & wb.rd==ex.rs1.
  - else 00.
  - MEM has priority over WB (youngest value). Outputs 00 when ex.valid=0.
- Reset:
  - All records invalid with fields 0.
  - All control outputs 0, fwd selects 00, counters 0.
  - Reset mid-stall/flush discards state with no residual stall next cycle.
- Latency: hazard controls are combinational on the current-cycle inputs. Record updates take effect at the next rising edge.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - perf_stall_cnt increments on each lu stall cycle.
  - perf_flush_cnt increments on each flush cycle.
  - Both wrap modulo 2^XLEN and hold while mem_busy=1.
- Undefined: both ports tied to 0, no counter flops.

Test Plan:
- Back-to-back ALU: `add x5,x1,x2` then `sub x6,x5,x3`. When sub is in EX, fwd_a_sel=01; no stall.
- Load-use: `lw x7,0(x1)` then `add x8,x7,x2`.
  - Exactly one cycle of stall_if=stall_id=bubble_ex=1.
  - Next cycle add in EX gets fwd_a_sel=10.
  - perf_stall_cnt=1 when enabled.
- x0 destination: `addi x0,x1,5` then `add x9,x0,x0` gives fwd_a_sel=fwd_b_sel=00 and no stall.
- Taken branch: ex_valid=1 with ex_branch_taken=1 while ID holds a load-use dependency.
  - flush_if=1, bubble_ex=1, stall_if=0.
  - perf_flush_cnt=1 and perf_stall_cnt=0.
- mem_busy=1 for 3 cycles mid-stream:
  - stall_if=stall_id=1 on all 3 cycles; records and counters unchanged.
  - Resumes with identical fwd selects.
- Reset asserted during a load-use stall: next cycle all outputs 0 and ex/mem/wb_valid=0.
